// File: rtl/crc_engine_param.sv
// crc_engine_param: framed parallel-update CRC engine with a registered result handshake
module crc_engine_param #(
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0] INIT = CRC_W'(16'hFFFF),
  parameter logic [CRC_W-1:0] XOROUT = CRC_W'(16'h0000),
  parameter int DATA_W = 8,
  parameter int REFIN = 0,
  parameter int REFOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic [7:0]        drop_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CRC_W-1:0] crc, crc_n, crc_out_n, folded;
  logic [7:0] drop_n;
  logic accept;
  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] c, input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic [7:0] b;
    logic fb;
    r = c;
    for (int i = DATA_W/8-1; i >= 0; i--) begin
      for (int j = 0; j < 8; j++) b[j] = (REFIN != 0) ? d[i*8 + 7 - j] : d[i*8 + j];
      for (int j = 7; j >= 0; j--) begin
        fb = r[CRC_W-1] ^ b[j];
        r = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
    end
    return r;
  endfunction
  function automatic logic [CRC_W-1:0] finish(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = (REFOUT != 0) ? c[CRC_W-1-i] : c[i];
    return r ^ XOROUT;
  endfunction
  assign accept = in_valid & in_ready;
  assign folded = fold(in_sof ? INIT : crc, in_data);
  // next-state, running CRC, result capture and drop counting
  always_comb begin
    state_n = state;
    crc_n = crc;
    crc_out_n = crc_out;
    drop_n = drop_cnt;
    case (state)
      IDLE: if (accept) begin
        if (in_sof) begin
          crc_n = folded;
          state_n = in_eof ? DONE : RUN;
          crc_out_n = in_eof ? finish(folded) : crc_out;
        end else drop_n = drop_cnt + {7'd0, drop_cnt != 8'hFF};
      end
      RUN: if (accept) begin
        crc_n = folded;
        state_n = in_eof ? DONE : RUN;
        crc_out_n = in_eof ? finish(folded) : crc_out;
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      crc <= INIT;
      crc_out <= '0;
      drop_cnt <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      crc <= crc_n;
      crc_out <= crc_out_n;
      drop_cnt <= drop_n;
      in_ready <= state_n != DONE;
      out_valid <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_crc_engine_param.sv
// tb_crc_engine_param: table-driven and scoreboarded checks of crc_engine_param variants
module tb_crc_engine_param;
  logic clk = 0, rst = 1;
  logic iv = 0, is = 0, ie = 0, ordy = 1;
  logic [7:0] id = 0;
  logic ir8, ov8, irx, ovx, irk, ovk;
  logic [15:0] c8, cx, ck;
  logic [7:0] dc8, dcx, dck;
  logic iv32 = 0, is32 = 0, ie32 = 0, or32 = 1;
  logic [31:0] id32 = 0;
  logic ir32, ov32;
  logic [15:0] c32;
  logic [7:0] dc32;
  int checks = 0, errors = 0;
  typedef struct packed { logic [15:0] e8, ex, ek; } exp_t;
  typedef struct { logic [127:0] m; int n; logic [15:0] e8, ex, ek; } vec_t;
  exp_t q[$];
  vec_t tbl[5];
  always #5 clk = ~clk;
  crc_engine_param d8 (.clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir8), .in_data(id), .in_sof(is),
    .in_eof(ie), .out_valid(ov8), .out_ready(ordy), .crc_out(c8), .drop_cnt(dc8));
  crc_engine_param #(.INIT(16'h0000)) dx (.clk(clk), .rst(rst), .in_valid(iv), .in_ready(irx), .in_data(id),
    .in_sof(is), .in_eof(ie), .out_valid(ovx), .out_ready(ordy), .crc_out(cx), .drop_cnt(dcx));
  crc_engine_param #(.INIT(16'h0000), .REFIN(1), .REFOUT(1)) dk (.clk(clk), .rst(rst), .in_valid(iv),
    .in_ready(irk), .in_data(id), .in_sof(is), .in_eof(ie), .out_valid(ovk), .out_ready(ordy), .crc_out(ck),
    .drop_cnt(dck));
  crc_engine_param #(.DATA_W(32)) d32 (.clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
    .in_sof(is32), .in_eof(ie32), .out_valid(ov32), .out_ready(or32), .crc_out(c32), .drop_cnt(dc32));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] model(input int mode, input logic [127:0] m, input int n);
    logic [15:0] c;
    logic [7:0] b;
    c = (mode == 0) ? 16'hFFFF : 16'h0000;
    for (int k = 0; k < n; k++) begin
      b = m[127-8*k -: 8];
      if (mode == 2) begin
        c ^= {8'h00, b};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end else begin
        c ^= {b, 8'h00};
        for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction
  function automatic vec_t mk(input logic [127:0] v, input int n);
    vec_t r;
    r.m = v << (128 - 8*n);
    r.n = n;
    r.e8 = model(0, r.m, n);
    r.ex = model(1, r.m, n);
    r.ek = model(2, r.m, n);
    return r;
  endfunction
  // scoreboard: compare each delivered result against the oldest expected entry
  always @(negedge clk) begin
    if (!rst && ov8 && ordy) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("crc_default", c8, e.e8);
        chk("crc_xmodem", cx, e.ex);
        chk("crc_kermit", ck, e.ek);
      end
    end
  end
  task automatic beat(input logic [7:0] b, input logic sof, input logic eof);
    int t;
    t = 0;
    while (!ir8 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!ir8) chk("in_ready_timeout", 0, 1);
    iv = 1; id = b; is = sof; ie = eof;
    @(posedge clk); #1;
    iv = 0; is = 0; ie = 0;
  endtask
  task automatic frame(input vec_t v, input string name);
    for (int k = 0; k < v.n; k++) begin
      if (k == v.n - 1) q.push_back('{v.e8, v.ex, v.ek});
      beat(v.m[127-8*k -: 8], k == 0, k == v.n - 1);
    end
    chk({name, "_latency"}, ov8, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{128'h313233343536373839 << 56, 9, 16'h29B1, 16'h31C3, 16'h2189};
    tbl[1] = mk(128'h41, 1);
    tbl[2] = mk(128'h3132333435363738, 8);
    tbl[3] = mk(128'h00FF8001, 4);
    tbl[4] = mk(128'h3132, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", ir8, 0);
    chk("reset_out_valid", ov8, 0);
    chk("reset_crc_out", c8, 0);
    chk("reset_drop_cnt", dc8, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", ir8, 1);
    for (int i = 0; i < 5; i++) frame(tbl[i], $sformatf("tbl%0d", i));
    @(posedge clk); #1;
    // 32-bit instance over the same eight bytes as tbl[2]
    iv32 = 1; id32 = 32'h31323334; is32 = 1;
    @(posedge clk); #1;
    id32 = 32'h35363738; is32 = 0; ie32 = 1;
    @(posedge clk); #1;
    iv32 = 0; ie32 = 0;
    chk("w32_out_valid", ov32, 1);
    chk("w32_crc_model", c32, model(0, tbl[2].m, 8));
    chk("w32_crc_vs_table", c32, tbl[2].e8);
    @(posedge clk); #1;
    chk("w32_released", ov32, 0);
    // back-pressure: result must hold while out_ready is low, input ignored
    ordy = 0;
    frame(tbl[0], "stall");
    for (int i = 0; i < 5; i++) begin
      iv = 1; id = 8'hAA; is = 1; ie = 1;
      @(posedge clk); #1;
      chk("stall_crc", c8, 16'h29B1);
      chk("stall_out_valid", ov8, 1);
      chk("stall_in_ready", ir8, 0);
    end
    iv = 0; is = 0; ie = 0;
    ordy = 1;
    @(posedge clk); #1;
    chk("release_out_valid", ov8, 0);
    chk("release_in_ready", ir8, 1);
    // words outside a frame are dropped and counted
    for (int i = 0; i < 3; i++) beat(8'h55, 0, 0);
    chk("drop_cnt_3", dc8, 3);
    chk("drop_no_out", ov8, 0);
    for (int i = 0; i < 260; i++) beat(8'h55, 0, 0);
    chk("drop_cnt_sat", dc8, 255);
    // sof mid-frame aborts the partial frame
    beat(8'h31, 1, 0);
    beat(8'h32, 0, 0);
    frame(tbl[0], "restart");
    @(posedge clk); #1;
    // reset mid-frame discards everything
    for (int k = 0; k < 4; k++) beat(tbl[0].m[127-8*k -: 8], k == 0, 0);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_in_ready", ir8, 0);
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_drop_cnt", dc8, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("postrst_out_valid", ov8, 0);
    frame(tbl[0], "postrst");
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
